// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle main control unit for the MIPS core.
// Sequences fetch/decode/execute/memory/write-back over a shared ALU and a
// single memory port, with a memory watchdog, illegal-instruction trap and a
// retired-instruction counter.
// Ports:
//   clk, rst_n            - clock (rising edge), async active-low reset
//   run                   - fetch enable, sampled at instruction boundaries
//   opcode, funct         - IR[31:26], IR[5:0]
//   mem_ready             - memory completes the current request this cycle
//   mem_req..alu_op       - datapath / memory controls (registered, except
//                           ir_write/pc_write which follow mem_ready in FETCH)
//   fault, fault_code     - sticky fault flag and cause (01 timeout, 10 illegal)
//   retired               - count of completed instructions
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_src,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned RET_W = 32;

  localparam logic [OP_W-1:0] OP_RTYPE    = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ      = 6'b000100;
  localparam logic [OP_W-1:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [OP_W-1:0] OP_LW       = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW       = 6'b101011;
  localparam logic [OP_W-1:0] FN_CLZ      = 6'b100000;
  localparam logic [OP_W-1:0] FN_CLO      = 6'b100001;

  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;

  localparam bit             WD_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXEC, S_ALUWB, S_BRANCH, S_FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic [1:0]       code_nxt;
  logic             retire, mem_wait, wd_expire;

  logic       mem_req_nxt, mem_we_nxt, i_or_d_nxt, pc_write_cond_nxt, pc_src_nxt;
  logic       reg_write_nxt, reg_dst_nxt, mem_to_reg_nxt, alu_src_a_nxt, fault_nxt;
  logic [1:0] alu_src_b_nxt;
  logic [2:0] alu_op_nxt;

  // Watchdog fires on the cycle whose increment would reach MEM_TIMEOUT,
  // so a memory state lasts at most MEM_TIMEOUT cycles; mem_ready wins.
  assign wd_expire = WD_EN && !mem_ready && (wait_cnt == WD_LAST);

  // IR and PC load on the handshake cycle itself, so these follow mem_ready.
  assign ir_write = (state == S_FETCH) && mem_ready;
  assign pc_write = (state == S_FETCH) && mem_ready;

  // Next state, watchdog counter, and controls decoded for the next state.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = wait_cnt;
    code_nxt          = fault_code;
    retire            = 1'b0;
    mem_wait          = 1'b0;
    mem_req_nxt       = 1'b0;
    mem_we_nxt        = 1'b0;
    i_or_d_nxt        = 1'b0;
    pc_write_cond_nxt = 1'b0;
    pc_src_nxt        = 1'b0;
    reg_write_nxt     = 1'b0;
    reg_dst_nxt       = 1'b0;
    mem_to_reg_nxt    = 1'b0;
    alu_src_a_nxt     = 1'b0;
    alu_src_b_nxt     = 2'b00;
    alu_op_nxt        = 3'b000;
    fault_nxt         = 1'b0;

    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        mem_wait = !mem_ready;
        if (mem_ready)      state_nxt = S_DECODE;
        else if (wd_expire) begin state_nxt = S_FAULT; code_nxt = FC_TIMEOUT; end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_SPECIAL2: begin
            if (funct == FN_CLO || funct == FN_CLZ) state_nxt = S_EXEC;
            else begin state_nxt = S_FAULT; code_nxt = FC_ILLEGAL; end
          end
          default: begin state_nxt = S_FAULT; code_nxt = FC_ILLEGAL; end
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        mem_wait = !mem_ready;
        if (mem_ready)      state_nxt = S_MEMWB;
        else if (wd_expire) begin state_nxt = S_FAULT; code_nxt = FC_TIMEOUT; end
      end
      S_MEMWR: begin
        mem_wait = !mem_ready;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = run ? S_FETCH : S_IDLE;
        end else if (wd_expire) begin
          state_nxt = S_FAULT;
          code_nxt  = FC_TIMEOUT;
        end
      end
      S_EXEC:   state_nxt = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: begin
        retire    = 1'b1;
        state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase

    if (state_nxt != state) cnt_nxt = '0;
    else if (mem_wait)      cnt_nxt = wait_cnt + CNT_W'(1);

    case (state_nxt)
      S_FETCH: begin
        mem_req_nxt   = 1'b1;
        alu_src_b_nxt = 2'b01;
        alu_op_nxt    = 3'b101;
      end
      S_DECODE: begin
        alu_src_b_nxt = 2'b11;
        alu_op_nxt    = 3'b101;
      end
      S_MEMADR: begin
        alu_src_a_nxt = 1'b1;
        alu_src_b_nxt = 2'b10;
        alu_op_nxt    = (opcode == OP_SW) ? 3'b110 : 3'b101;
      end
      S_MEMRD: begin
        mem_req_nxt = 1'b1;
        i_or_d_nxt  = 1'b1;
      end
      S_MEMWB: begin
        reg_write_nxt  = 1'b1;
        mem_to_reg_nxt = 1'b1;
      end
      S_MEMWR: begin
        mem_req_nxt = 1'b1;
        mem_we_nxt  = 1'b1;
        i_or_d_nxt  = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_nxt = 1'b1;
        if (opcode == OP_SPECIAL2) alu_op_nxt = (funct == FN_CLO) ? 3'b001 : 3'b010;
      end
      S_ALUWB: begin
        reg_write_nxt = 1'b1;
        reg_dst_nxt   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_nxt     = 1'b1;
        alu_op_nxt        = 3'b111;
        pc_src_nxt        = 1'b1;
        pc_write_cond_nxt = 1'b1;
      end
      S_FAULT:  fault_nxt = 1'b1;
      default: ;
    endcase
  end

  // State, counters and registered controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      retired       <= '0;
      fault_code    <= 2'b00;
      fault         <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      i_or_d        <= 1'b0;
      pc_write_cond <= 1'b0;
      pc_src        <= 1'b0;
      reg_write     <= 1'b0;
      reg_dst       <= 1'b0;
      mem_to_reg    <= 1'b0;
      alu_src_a     <= 1'b0;
      alu_src_b     <= 2'b00;
      alu_op        <= 3'b000;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= cnt_nxt;
      if (retire) retired <= retired + RET_W'(1);
      fault_code    <= code_nxt;
      fault         <= fault_nxt;
      mem_req       <= mem_req_nxt;
      mem_we        <= mem_we_nxt;
      i_or_d        <= i_or_d_nxt;
      pc_write_cond <= pc_write_cond_nxt;
      pc_src        <= pc_src_nxt;
      reg_write     <= reg_write_nxt;
      reg_dst       <= reg_dst_nxt;
      mem_to_reg    <= mem_to_reg_nxt;
      alu_src_a     <= alu_src_a_nxt;
      alu_src_b     <= alu_src_b_nxt;
      alu_op        <= alu_op_nxt;
    end
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle main control unit for the MIPS core. It sequences fetch, decode, execute, memory access and write-back over a shared ALU and a single memory port. It drives the 3-bit ALU-op code consumed by the ALU control decoder and handshakes with memory via req/ready. It also provides a memory watchdog, illegal-instruction detection and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory state may wait for mem_ready; 0 disables the watchdog
CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  enables fetching; sampled at instruction boundaries
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write when 1, read when 0
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
ir_write  out  1  load IR
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load qualified externally by ALU zero
pc_src  out  1  PC source: 0=ALU result, 1=ALUOut
reg_write  out  1  register file write
reg_dst  out  1  destination: 0=rt, 1=rd
mem_to_reg  out  1  write-back data: 0=ALUOut, 1=MDR
alu_src_a  out  1  A operand: 0=PC, 1=rs
alu_src_b  out  2  B operand: 00=rt, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  3  000 R-type (funct passed through), 001 CLO, 010 CLZ, 101 add (LW/PC), 110 add (SW), 111 sub (BEQ)
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 memory timeout, 10 illegal instruction
retired  out  32  count of completed instructions

Behaviour:
- Reset (async, any state, including mid-access): state=IDLE, wait_cnt=0, retired=0, fault=0, fault_code=00. All outputs are 0 while in IDLE.
- Outputs are decoded from state (Moore), except ir_write/pc_write in FETCH, which are qualified by mem_ready. Any output not listed for a state is 0.
- IDLE: next is FETCH if run=1.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=101. Holds until mem_ready=1; in that cycle ir_write=1 and pc_write=1, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=101 (branch target into ALUOut). Next state:
  - LW (100011) or SW (101011): MEMADR.
  - R-type (000000): EXEC.
  - BEQ (000100): BRANCH.
  - SPECIAL2 (011100) with funct 100001 (CLO) or 100000 (CLZ): EXEC.
  - Anything else: FAULT, code 10.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=101 (LW) or 110 (SW). Next is MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req=1, i_or_d=1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Completes instruction.
- MEMWR: mem_req=1, mem_we=1, i_or_d=1. Holds until mem_ready; completes instruction.
- EXEC: alu_src_a=1, alu_src_b=00. alu_op=000 for R-type, 001 for CLO, 010 for CLZ. Next is ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Completes instruction.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=111, pc_src=1, pc_write_cond=1. Completes instruction.
- Completes instruction: retired increments (wraps at 2^32-1 to 0). Next is FETCH if run=1, else IDLE.
- Cycle counts (zero-wait memory): LW=5, SW=4, R/CLO/CLZ=4, BEQ=3.
- Watchdog (applies in FETCH, MEMRD and MEMWR):
  - wait_cnt clears on entry to each of these states and increments every cycle mem_ready=0.
  - If MEM_TIMEOUT≠0 and wait_cnt reaches MEM_TIMEOUT while mem_ready is still 0: go to FAULT, code 01, drop mem_req.
  - mem_ready in the same cycle as the limit wins; no fault.
- FAULT: fault=1, fault_code held, all other outputs 0. Exits only via rst_n. retired does not increment for a faulting instruction.
- Deasserting run mid-instruction has no effect until the instruction completes.

Test Plan:
- Reset then run=1, zero-wait memory, LW opcode: states FETCH,DECODE,MEMADR,MEMRD,MEMWB; alu_op 101 in MEMADR; reg_write=1 and mem_to_reg=1 in cycle 5; retired=1.
- SW with mem_ready delayed 3 cycles in MEMWR: mem_req=1 and mem_we=1 held 4 cycles; no fault; alu_op=110 in MEMADR; retired=1.
- Sequence R-type (funct 100000), CLO, CLZ, BEQ: alu_op in EXEC = 000, 001, 010; BRANCH has alu_op=111 and pc_write_cond=1; retired=4 after 15 cycles.
- opcode 111111, or SPECIAL2 with funct 000010: FAULT after DECODE; fault=1, fault_code=10; state held until rst_n low.
- MEM_TIMEOUT=16, mem_ready stuck 0 in FETCH: fault_code=01 exactly 16 cycles after FETCH entry. With mem_ready=1 on the 16th cycle: no fault.
- rst_n low mid-MEMRD: all outputs 0 immediately and retired=0. run=0 at ALUWB: returns to IDLE with no further mem_req.
